// File: rtl/dut_vector_sequencer.sv
// Purpose: replays stored {stimulus, expected} vectors into a core, pulsing its reset per vector, and scores write_out.
// Latency: RST_CYCLES + c cycles per vector (c = run cycle of the verdict); minimum RST_CYCLES+1.
// Backpressure: none; start and vec_we are ignored while a sequence is busy.
module dut_vector_sequencer #(
  parameter int DATA_W     = 16,
  parameter int NUM_VEC    = 4,
  parameter int IDX_W      = 2,
  parameter int RST_CYCLES = 1,
  parameter int TIMEOUT    = 64,
  parameter int CHECK_MODE = 0,
  parameter int CNT_W      = 8
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              vec_we,
  input  logic [IDX_W-1:0]  vec_addr,
  input  logic [DATA_W-1:0] vec_in,
  input  logic [DATA_W-1:0] vec_exp,
  input  logic              start,
  input  logic [DATA_W-1:0] dut_write_out,
  output logic              dut_rst,
  output logic [DATA_W-1:0] dut_read_in,
  output logic              busy,
  output logic              done,
  output logic              all_pass,
  output logic [CNT_W-1:0]  pass_count,
  output logic [CNT_W-1:0]  fail_count,
  output logic              first_fail_vld,
  output logic [IDX_W-1:0]  first_fail_idx
);

  localparam int RC_W = $clog2(RST_CYCLES + 1);
  localparam int C_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_RESET, S_RUN, S_DONE} state_t;

  state_t            state, state_nx;
  logic [DATA_W-1:0] mem_in  [NUM_VEC];
  logic [DATA_W-1:0] mem_exp [NUM_VEC];
  logic [IDX_W-1:0]  idx;
  logic [RC_W-1:0]   rcnt;
  logic [C_W-1:0]    rcyc;
  logic [DATA_W-1:0] stim_q;
  logic              start_acc;
  logic              verdict;
  logic              vpass;
  logic              match;
  logic              last_vec;
  logic              rst_last;
  logic              addr_ok;

  assign addr_ok  = ({1'b0, vec_addr} < (IDX_W+1)'(NUM_VEC));
  assign last_vec = (idx == IDX_W'(NUM_VEC - 1));
  assign rst_last = (rcnt == RC_W'(RST_CYCLES));
  assign all_pass = done && (fail_count == '0);

  // Vector memory: deliberately outside reset so a loaded table survives rst.
  always_ff @(posedge clock) begin
    if (vec_we && !busy && addr_ok) begin
      mem_in[vec_addr]  <= vec_in;
      mem_exp[vec_addr] <= vec_exp;
    end
  end

  // State register.
  always_ff @(posedge clock) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next state, verdict decode and core-facing outputs.
  always_comb begin
    state_nx    = state;
    start_acc   = 1'b0;
    verdict     = 1'b0;
    vpass       = 1'b0;
    match       = (dut_write_out == mem_exp[idx]);
    busy        = (state == S_RESET) || (state == S_RUN);
    done        = (state == S_DONE);
    dut_rst     = (state != S_RUN);
    dut_read_in = busy ? mem_in[idx] : stim_q;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          start_acc = 1'b1;
          state_nx  = S_RESET;
        end
      end
      S_RESET: begin
        if (rst_last) state_nx = S_RUN;
      end
      S_RUN: begin
        if (CHECK_MODE == 0) begin
          if (match) begin
            verdict = 1'b1;
            vpass   = 1'b1;
          end else if (rcyc == C_W'(TIMEOUT)) begin
            verdict = 1'b1;
          end
        end else if (rcyc == C_W'(TIMEOUT)) begin
          verdict = 1'b1;
          vpass   = match;
        end
        if (verdict) state_nx = last_vec ? S_DONE : S_RESET;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Sequencing counters, scoreboard counts and the stimulus held through DONE.
  always_ff @(posedge clock) begin
    if (rst) begin
      idx            <= '0;
      rcnt           <= '0;
      rcyc           <= '0;
      stim_q         <= '0;
      pass_count     <= '0;
      fail_count     <= '0;
      first_fail_vld <= 1'b0;
      first_fail_idx <= '0;
    end else begin
      if (busy) stim_q <= mem_in[idx];
      if (start_acc) begin
        idx            <= '0;
        rcnt           <= RC_W'(1);
        pass_count     <= '0;
        fail_count     <= '0;
        first_fail_vld <= 1'b0;
        first_fail_idx <= '0;
      end
      if (state == S_RESET) begin
        if (rst_last) rcyc <= C_W'(1);
        else          rcnt <= rcnt + 1'b1;
      end
      if (state == S_RUN) begin
        rcyc <= rcyc + 1'b1;
        if (verdict) begin
          if (vpass) begin
            if (pass_count != {CNT_W{1'b1}}) pass_count <= pass_count + 1'b1;
          end else begin
            if (fail_count != {CNT_W{1'b1}}) fail_count <= fail_count + 1'b1;
            if (!first_fail_vld) begin
              first_fail_vld <= 1'b1;
              first_fail_idx <= idx;
            end
          end
          if (!last_vec) begin
            idx  <= idx + 1'b1;
            rcnt <= RC_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_dut_vector_sequencer.sv
module tb_dut_vector_sequencer;

  typedef struct {
    bit pass;
    int cyc;
    int low;
  } vrec_t;

  typedef struct {
    int          pc;
    int          fc;
    bit          ffv;
    int          ffi;
    logic [15:0] lastin;
  } rrec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        vec_we;
  logic [1:0]  vec_addr;
  logic [15:0] vec_in;
  logic [15:0] vec_exp;
  logic        start;

  logic        drst [2];
  logic        busy [2];
  logic        done [2];
  logic        allp [2];
  logic        ffv  [2];
  logic [1:0]  ffi  [2];
  logic [7:0]  pc   [2];
  logic [7:0]  fc   [2];
  logic [15:0] rdin [2];
  logic [15:0] wout [2];

  logic [15:0] core0;
  int          kb = 0;
  int          edge_n = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  logic [15:0] m_in  [4];
  logic [15:0] m_exp [4];

  vrec_t qv0[$];
  vrec_t qv1[$];
  rrec_t qr0[$];
  rrec_t qr1[$];

  int last_e [2] = '{0, 0};
  int low    [2] = '{0, 0};
  int psum   [2] = '{0, 0};
  int ppass  [2] = '{0, 0};
  bit busy_p [2] = '{0, 0};
  bit done_p [2] = '{0, 0};

  always #5 clk = ~clk;

  // Instance 0: wait-for-match, TIMEOUT 64, 1 reset cycle. Instance 1: fixed latency, TIMEOUT 3, 2 reset cycles.
  for (genvar g = 0; g < 2; g++) begin : u
    dut_vector_sequencer #(
      .DATA_W(16), .NUM_VEC(4), .IDX_W(2), .RST_CYCLES(g == 0 ? 1 : 2),
      .TIMEOUT(g == 0 ? 64 : 3), .CHECK_MODE(g), .CNT_W(8)
    ) dut (
      .clock(clk), .rst(rst), .vec_we(vec_we), .vec_addr(vec_addr), .vec_in(vec_in),
      .vec_exp(vec_exp), .start(start), .dut_write_out(wout[g]), .dut_rst(drst[g]),
      .dut_read_in(rdin[g]), .busy(busy[g]), .done(done[g]), .all_pass(allp[g]),
      .pass_count(pc[g]), .fail_count(fc[g]), .first_fail_vld(ffv[g]), .first_fail_idx(ffi[g])
    );
  end

  // Second core: output depends on run cycle c, profile in stimulus bits [1:0].
  function automatic logic [15:0] core_b(input logic [15:0] in, input int c);
    logic [15:0] good;
    good = in >> 4;
    case (in[1:0])
      2'd0:    return good;
      2'd1:    return (c == 1) ? good : ~good;
      2'd2:    return (c >= 3) ? good : ~good;
      default: return ~good;
    endcase
  endfunction

  always @(posedge clk) core0 <= rdin[0] >> 4;
  always @(posedge clk) begin
    if (drst[1]) kb <= 0;
    else         kb <= kb + 1;
  end
  always @(posedge clk) edge_n <= edge_n + 1;
  always_comb begin
    wout[0] = core0;
    wout[1] = core_b(rdin[1], kb + 1);
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int a, input logic [15:0] vin, input logic [15:0] vexp);
    vec_we = 1'b1; vec_addr = 2'(a); vec_in = vin; vec_exp = vexp;
    m_in[a] = vin; m_exp[a] = vexp;
    tick;
    vec_we = 1'b0;
  endtask

  // Reference model: per-vector verdict and latency from the behavioural rules.
  task automatic push_model(input int abort_at);
    for (int g = 0; g < 2; g++) begin
      int cum, p, f, fi, rstc, rc;
      bit fv, ok;
      vrec_t v;
      rrec_t r;
      cum = 0; p = 0; f = 0; fv = 0; fi = 0;
      rstc = (g == 0) ? 1 : 2;
      for (int i = 0; i < 4; i++) begin
        if (g == 0) begin
          ok = (m_exp[i] == (m_in[i] >> 4));
          rc = ok ? 1 : 64;
        end else begin
          ok = (m_exp[i] == core_b(m_in[i], 3));
          rc = 3;
        end
        cum += rstc + rc;
        if (abort_at > 0 && cum >= abort_at) break;
        v.pass = ok; v.cyc = rstc + rc; v.low = rc;
        if (g == 0) qv0.push_back(v); else qv1.push_back(v);
        if (ok) p++;
        else begin
          f++;
          if (!fv) begin fv = 1; fi = i; end
        end
      end
      if (abort_at == 0) begin
        r.pc = p; r.fc = f; r.ffv = fv; r.ffi = fi; r.lastin = m_in[3];
        if (g == 0) qr0.push_back(r); else qr1.push_back(r);
      end
    end
  endtask

  task automatic run_seq(input int abort_at);
    int k;
    push_model(abort_at);
    start = 1'b1;
    tick;
    start = 1'b0;
    vec_we = 1'b0;
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("g%0d start clears pass_count", g), pc[g], 0);
      chk($sformatf("g%0d start clears fail_count", g), fc[g], 0);
      chk($sformatf("g%0d start clears first_fail_vld", g), ffv[g], 0);
      chk($sformatf("g%0d busy after start", g), busy[g], 1);
      chk($sformatf("g%0d done cleared by start", g), done[g], 0);
      chk($sformatf("g%0d read_in vec0 in reset", g), rdin[g], m_in[0]);
    end
    if (abort_at > 0) begin
      repeat (3) tick;
      vec_we = 1'b1; vec_addr = 2'd2; vec_in = 16'hDEAD; vec_exp = 16'hBEEF;
      tick;
      vec_we = 1'b0;
      repeat (abort_at - 5) tick;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      for (int g = 0; g < 2; g++) begin
        chk($sformatf("g%0d abort busy", g), busy[g], 0);
        chk($sformatf("g%0d abort done", g), done[g], 0);
        chk($sformatf("g%0d abort pass_count", g), pc[g], 0);
        chk($sformatf("g%0d abort fail_count", g), fc[g], 0);
        chk($sformatf("g%0d abort dut_rst", g), drst[g], 1);
        chk($sformatf("g%0d abort read_in", g), rdin[g], 0);
      end
    end else begin
      k = 0;
      while (!(done[0] && done[1]) && k < 2000) begin
        tick;
        k++;
      end
      chk("run completes within bound", (done[0] && done[1]) ? 1 : 0, 1);
    end
    tick;
  endtask

  // Monitor: each verdict and each completed run pops the model's expectation.
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      int    sum;
      bit    rose, got_pass, empty;
      vrec_t v;
      rrec_t r;
      sum  = int'(pc[g]) + int'(fc[g]);
      rose = busy[g] && !busy_p[g];
      if (rose) begin
        last_e[g] = edge_n;
        low[g]    = 0;
      end
      if (busy[g] && !drst[g]) low[g]++;
      if (sum != psum[g]) begin
        if (!rose && sum == psum[g] + 1) begin
          got_pass = (int'(pc[g]) != ppass[g]);
          empty = (g == 0) ? (qv0.size() == 0) : (qv1.size() == 0);
          if (empty) chk($sformatf("g%0d unexpected verdict", g), 1, 0);
          else begin
            if (g == 0) v = qv0.pop_front(); else v = qv1.pop_front();
            chk($sformatf("g%0d vector verdict", g), got_pass, v.pass);
            chk($sformatf("g%0d vector cycles", g), edge_n - last_e[g], v.cyc);
            chk($sformatf("g%0d dut_rst low cycles", g), low[g], v.low);
          end
          last_e[g] = edge_n;
          low[g]    = 0;
        end
        psum[g]  = sum;
        ppass[g] = int'(pc[g]);
      end
      if (done[g] && !done_p[g]) begin
        empty = (g == 0) ? (qr0.size() == 0) : (qr1.size() == 0);
        if (empty) chk($sformatf("g%0d unexpected done", g), 1, 0);
        else begin
          if (g == 0) r = qr0.pop_front(); else r = qr1.pop_front();
          chk($sformatf("g%0d pass_count", g), pc[g], r.pc);
          chk($sformatf("g%0d fail_count", g), fc[g], r.fc);
          chk($sformatf("g%0d all_pass", g), allp[g], (r.fc == 0) ? 1 : 0);
          chk($sformatf("g%0d first_fail_vld", g), ffv[g], r.ffv);
          chk($sformatf("g%0d first_fail_idx", g), ffi[g], r.ffi);
          chk($sformatf("g%0d busy in done", g), busy[g], 0);
          chk($sformatf("g%0d dut_rst in done", g), drst[g], 1);
          chk($sformatf("g%0d read_in held in done", g), rdin[g], r.lastin);
        end
      end
      busy_p[g] = busy[g];
      done_p[g] = done[g];
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] vin;
    rst = 1'b1; vec_we = 1'b0; vec_addr = '0; vec_in = '0; vec_exp = '0; start = 1'b0;
    tick;
    tick;
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("g%0d reset dut_rst", g), drst[g], 1);
      chk($sformatf("g%0d reset busy", g), busy[g], 0);
      chk($sformatf("g%0d reset done", g), done[g], 0);
      chk($sformatf("g%0d reset pass_count", g), pc[g], 0);
      chk($sformatf("g%0d reset fail_count", g), fc[g], 0);
      chk($sformatf("g%0d reset read_in", g), rdin[g], 0);
      chk($sformatf("g%0d reset first_fail_vld", g), ffv[g], 0);
    end
    rst = 1'b0;

    // All echo-correct; second core profiles 0,1,2,3 give pass,fail,pass,fail.
    load(0, 16'h1230, 16'h0123);
    load(1, 16'h4561, 16'h0456);
    load(2, 16'h7892, 16'h0789);
    load(3, 16'hABC3, 16'h0ABC);
    run_seq(0);

    // Vector 2 expectation wrong: timeout on the wait-for-match instance.
    load(2, 16'h7892, 16'h0788);
    run_seq(0);

    // Vectors 1 and 3 wrong, then rerun to see counts clear.
    load(2, 16'h7892, 16'h0789);
    load(1, 16'h4560, 16'h1456);
    load(3, 16'hABC2, 16'h0ABD);
    run_seq(0);
    run_seq(0);

    // Write lands in the same cycle that start is accepted.
    vec_we = 1'b1; vec_addr = 2'd0; vec_in = 16'h5550; vec_exp = 16'h0554;
    m_in[0] = 16'h5550; m_exp[0] = 16'h0554;
    run_seq(0);

    // Randomised rounds.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 4; i++) begin
        vin = 16'($urandom);
        if ($urandom_range(0, 3) == 0) load(i, vin, (vin >> 4) ^ 16'($urandom_range(1, 255)));
        else                            load(i, vin, vin >> 4);
      end
      run_seq(0);
    end

    // Abort during vector 1 (run cycle 5 on instance 0); write while busy must be dropped.
    load(0, 16'h2220, 16'h0222);
    load(1, 16'h3330, 16'h0334);
    load(2, 16'h4440, 16'h0444);
    load(3, 16'h6662, 16'h0666);
    run_seq(8);
    run_seq(0);

    repeat (3) tick;
    chk("all expectations consumed", qv0.size() + qv1.size() + qr0.size() + qr1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
